time_update_ctrl: RTL and testbench
===================================

// Module: time_update_ctrl
// PURPOSE
//  Sequences all updates to the HH:MM:SS BCD time registers shown by the VGA clock.
//  Sources of update:
//   - 1 Hz tick from an internal prescaler on clk.
//   - Three user adjust buttons: adj_hrs, adj_min, adj_sec.
//  Arbitrates these sources so at most one update hits the digits per cycle.
//  No tick and no press is ever lost. Feeds the digit renderer in the pixel domain.
// PARAMETERS
//  CLK_HZ      31_500_000  clk cycles per second; prescaler wraps at CLK_HZ-1
//  REPEAT_DIV  8_000_000   cycles between auto-repeat increments while a button is held
// PORTS
//  clk      in   1  system clock
//  reset    in   1  synchronous, active-high reset
//  adj_hrs  in   1  hours adjust button, active-high, asynchronous to clk
//  adj_min  in   1  minutes adjust button, active-high, asynchronous to clk
//  adj_sec  in   1  seconds adjust button, active-high, asynchronous to clk
//  sec_u    out  4  seconds units, BCD 0..9
//  sec_d    out  3  seconds tens, 0..5
//  min_u    out  4  minutes units, BCD 0..9
//  min_d    out  3  minutes tens, 0..5
//  hrs_u    out  4  hours units, BCD 0..9 (0..3 when hrs_d==2)
//  hrs_d    out  2  hours tens, 0..2
//  update   out  1  1-cycle pulse; high in the same cycle new digit values appear
// BEHAVIOUR
//  Reset:
//   - All digit outputs 0 (00:00:00); update 0; prescaler 0.
//   - All synchroniser, edge and pending flags 0; repeat counters 0.
//   - Reset asserted mid-operation discards pending requests; no update follows reset release.
//  Prescaler:
//   - Counts 0..CLK_HZ-1, wraps to 0.
//   - tick is asserted combinationally while count==CLK_HZ-1.
//  Button path, per button:
//   - 2-flop synchroniser, then rising-edge detect.
//   - Rising edge sets pend_x.
//   - Latency: input high before edge N -> pend_x set at N+2 -> digits change at N+3 if granted.
//  Arbitration, each cycle, fixed priority tick > hrs > min > sec:
//   - The highest-priority active source is granted; update=1 for that cycle.
//   - A granted pend_x clears on the same edge that updates the digits.
//   - Non-granted pends hold; they are served on later cycles in priority order.
//   - A new edge on a button whose pend is already set is absorbed (no double count).
//  Tick update:
//   - Full carry chain: sec_u 9->0 carries to sec_d.
//   - Carries continue sec_d 5->0 -> minutes -> hours.
//   - 23:59:59 -> 00:00:00.
//  Adjust updates increment one field with no carry into the next field:
//   - sec: 59->00.
//   - min: 59->00.
//   - hrs: 23->00; 09->10, 19->20.
//  update is a registered pulse and is never high for two consecutive cycles from one source.
// CONFIGURATION
//  AUTOREPEAT_EN defined:
//   - While a synchronised button stays high, a per-button counter counts 0..REPEAT_DIV-1.
//   - On each wrap the counter sets pend_x again.
//   - The first repeat occurs REPEAT_DIV cycles after the initial edge, then every REPEAT_DIV cycles.
//   - Release clears the counter.
//  AUTOREPEAT_EN undefined:
//   - Exactly one increment per press, regardless of hold time.
//   - Repeat counters are not instantiated.
// TESTING (bench uses CLK_HZ=10, REPEAT_DIV=4)
//  1. Release reset, run 100 cycles -> time 00:00:10; update pulses exactly 10 times, 10 cycles apart.
//  2. Preload 23:59:59 via 1 tick short of rollover, next tick -> 00:00:00, single update pulse.
//  3. Pulse adj_min high for 3 cycles at 00:59:30 -> 00:00:30 within 3 cycles; hours unchanged.
//  4. Raise adj_hrs, adj_min, adj_sec together, coinciding with a tick:
//     -> four separate update pulses in order tick, hrs, min, sec; final 01:01:02 from 00:00:00.
//  5. Hold adj_sec for 20 cycles:
//     -> +1 with AUTOREPEAT_EN undefined;
//     -> +1 then one extra increment every 4 cycles (total 5) with it defined.
//  6. Assert reset for 1 cycle with pend_hrs set at 12:34:56 -> 00:00:00; no update for next 9 cycles.

Source files
------------

// File: rtl/time_update_ctrl.sv
// time_update_ctrl: arbitrates the 1 Hz tick and three adjust buttons onto the HH:MM:SS BCD digits.
// Define AUTOREPEAT_EN to make held buttons re-increment every REPEAT_DIV cycles.
module time_update_ctrl #(
    parameter int CLK_HZ     = 31_500_000,
    parameter int REPEAT_DIV = 8_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adj_hrs,
    input  logic       adj_min,
    input  logic       adj_sec,
    output logic [3:0] sec_u,
    output logic [2:0] sec_d,
    output logic [3:0] min_u,
    output logic [2:0] min_d,
    output logic [3:0] hrs_u,
    output logic [1:0] hrs_d,
    output logic       update
);
    localparam int PW = $clog2(CLK_HZ);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [2:0]    sync1_q, sync2_q, prev_q, pend_q, pend_d;
    logic [2:0]    rise, rep_set, gnt;
    logic [3:0]    sec_u_q, sec_u_d, min_u_q, min_u_d, hrs_u_q, hrs_u_d;
    logic [2:0]    sec_d_q, sec_d_d, min_d_q, min_d_d;
    logic [1:0]    hrs_d_q, hrs_d_d;
    logic          update_q, update_d;
    logic          s59, m59, h23, adv_s, adv_m, adv_h;

    assign tick  = pre_q == PW'(CLK_HZ - 1);
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign rise  = sync2_q & ~prev_q;

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DIV);
    // Counting starts the cycle after the edge so the first repeat lands REPEAT_DIV cycles after the press.
    for (genvar g = 0; g < 3; g++) begin : g_rep
        logic [RW-1:0] cnt_q, cnt_d;
        logic          held;
        assign held       = sync2_q[g] & prev_q[g];
        assign rep_set[g] = held & (cnt_q == RW'(REPEAT_DIV - 1));
        assign cnt_d      = held ? (rep_set[g] ? '0 : cnt_q + 1'b1) : '0;
        always_ff @(posedge clk) begin
            cnt_q <= reset ? '0 : cnt_d;
        end
    end
`else
    assign rep_set = '0;
`endif

    // Fixed priority: tick, then hours, minutes, seconds; losers keep their pend bit.
    assign gnt    = tick ? 3'b000 : pend_q[2] ? 3'b100 : pend_q[1] ? 3'b010 : pend_q[0] ? 3'b001 : 3'b000;
    assign pend_d = (pend_q & ~gnt) | rise | rep_set;

    assign s59   = sec_d_q == 3'd5 && sec_u_q == 4'd9;
    assign m59   = min_d_q == 3'd5 && min_u_q == 4'd9;
    assign h23   = hrs_d_q == 2'd2 && hrs_u_q == 4'd3;
    assign adv_s = tick | gnt[0];
    assign adv_m = (tick & s59) | gnt[1];
    assign adv_h = (tick & s59 & m59) | gnt[2];

    always_comb begin
        sec_u_d  = adv_s ? (sec_u_q == 4'd9 ? 4'd0 : sec_u_q + 4'd1) : sec_u_q;
        sec_d_d  = (adv_s && sec_u_q == 4'd9) ? (sec_d_q == 3'd5 ? 3'd0 : sec_d_q + 3'd1) : sec_d_q;
        min_u_d  = adv_m ? (min_u_q == 4'd9 ? 4'd0 : min_u_q + 4'd1) : min_u_q;
        min_d_d  = (adv_m && min_u_q == 4'd9) ? (min_d_q == 3'd5 ? 3'd0 : min_d_q + 3'd1) : min_d_q;
        hrs_u_d  = adv_h ? ((h23 || hrs_u_q == 4'd9) ? 4'd0 : hrs_u_q + 4'd1) : hrs_u_q;
        hrs_d_d  = adv_h ? (h23 ? 2'd0 : hrs_u_q == 4'd9 ? hrs_d_q + 2'd1 : hrs_d_q) : hrs_d_q;
        update_d = tick | (|pend_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            sec_u_q  <= '0;
            sec_d_q  <= '0;
            min_u_q  <= '0;
            min_d_q  <= '0;
            hrs_u_q  <= '0;
            hrs_d_q  <= '0;
            update_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            sync1_q  <= {adj_hrs, adj_min, adj_sec};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            pend_q   <= pend_d;
            sec_u_q  <= sec_u_d;
            sec_d_q  <= sec_d_d;
            min_u_q  <= min_u_d;
            min_d_q  <= min_d_d;
            hrs_u_q  <= hrs_u_d;
            hrs_d_q  <= hrs_d_d;
            update_q <= update_d;
        end
    end

    assign sec_u  = sec_u_q;
    assign sec_d  = sec_d_q;
    assign min_u  = min_u_q;
    assign min_d  = min_d_q;
    assign hrs_u  = hrs_u_q;
    assign hrs_d  = hrs_d_q;
    assign update = update_q;
endmodule

// File: tb/tb_time_update_ctrl.sv
// tb_time_update_ctrl: scoreboard bench for time_update_ctrl with CLK_HZ=10, REPEAT_DIV=4.
module tb_time_update_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [3:0] sec_u, min_u, hrs_u;
    logic [2:0] sec_d, min_d;
    logic [1:0] hrs_d;
    logic       update;
    logic [19:0] obs;

    time_update_ctrl #(.CLK_HZ(10), .REPEAT_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .adj_hrs(btn[2]), .adj_min(btn[1]), .adj_sec(btn[0]),
        .sec_u(sec_u), .sec_d(sec_d), .min_u(min_u), .min_d(min_d),
        .hrs_u(hrs_u), .hrs_d(hrs_d), .update(update)
    );

    always #5 clk = ~clk;
    assign obs = {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u};

`ifdef AUTOREPEAT_EN
    localparam int T5_SECS = 7;
`else
    localparam int T5_SECS = 3;
`endif

    int n_chk = 0, n_bad = 0, k = 0, n_upd = 0, ncyc = 0, last_upd = -1, base = 0;
    int mh = 0, mm = 0, ms = 0;
    bit tick_en = 1'b0, gap_on = 1'b0;
    logic [19:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic tk();
        ms++;
        if (ms == 60) begin
            ms = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
                mh = (mh + 1) % 24;
            end
        end
        q.push_back(pack(mh, mm, ms));
    endtask

    task automatic bump(input int b);
        if (b == 0) ms = (ms + 1) % 60;
        else if (b == 1) mm = (mm + 1) % 60;
        else mh = (mh + 1) % 24;
        q.push_back(pack(mh, mm, ms));
    endtask

    task automatic cycle();
        if (tick_en && (k + 1) % 10 == 0) tk();
        @(posedge clk);
        k++;
        #1;
    endtask

    // Launch only where the increment lands before the next tick, so queue order matches DUT order.
    task automatic press(input int b, input int h);
        bump(b);
        btn[b] = 1'b1;
        repeat (h) cycle();
        btn[b] = 1'b0;
        cycle();
    endtask

    task automatic do_reset(input int n);
        chk("rst_queue_empty", q.size(), 0);
        reset = 1'b1;
        mh = 0; mm = 0; ms = 0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_time", 32'(obs), 32'(pack(0, 0, 0)));
        chk("rst_upd", 32'(update), 0);
        reset = 1'b0;
        k = 0;
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (reset) last_upd = -1;
        if (update) begin
            n_upd++;
            if (q.size() == 0) chk("spare_update", q.size(), 1);
            else chk("upd_time", 32'(obs), 32'(q.pop_front()));
            if (gap_on && last_upd >= 0) chk("t1_gap", ncyc - last_upd, 10);
            last_upd = ncyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        do_reset(3);
        tick_en = 1'b1;
        gap_on = 1'b1;
        repeat (100) cycle();
        chk("t1_time", 32'(obs), 32'(pack(0, 0, 10)));
        cycle();
        gap_on = 1'b0;
        chk("t1_count", n_upd, 10);
        chk("t1_drain", q.size(), 0);

        while (pack(mh, mm, ms) != pack(23, 59, 59)) begin
            if (k % 10 <= 5) press(mh != 23 ? 2 : mm != 59 ? 1 : 0, 1);
            else cycle();
        end
        do cycle(); while (k % 10 != 0);
        chk("t2_roll", 32'(obs), 32'(pack(0, 0, 0)));
        chk("t2_upd", 32'(update), 1);
        cycle();
        chk("t2_single", 32'(update), 0);

        while (mm != 59) begin
            if (k % 10 <= 5) press(1, 1);
            else cycle();
        end
        while (k % 10 > 5) cycle();
        press(1, 3);
        chk("t3_time", 32'(obs), 32'(pack(mh, mm, ms)));
        chk("t3_min", 32'({min_d, min_u}), 0);
        chk("t3_hrs", 32'({hrs_d, hrs_u}), 0);
        cycle();
        chk("t3_drain", q.size(), 0);

        do_reset(2);
        tick_en = 1'b0;
        while (k < 6) cycle();
        tk();
        bump(2);
        bump(1);
        bump(0);
        btn = 3'b111;
        cycle();
        btn = 3'b000;
        while (k < 13) cycle();
        chk("t4_time", 32'(obs), 32'(pack(1, 1, 2)));
        chk("t4_upd", 32'(update), 1);
        cycle();
        chk("t4_drain", q.size(), 0);
        tick_en = 1'b1;

        do_reset(2);
        tick_en = 1'b0;
`ifdef AUTOREPEAT_EN
        bump(0); bump(0); tk(); bump(0); bump(0); tk(); bump(0);
`else
        bump(0); tk(); tk();
`endif
        btn[0] = 1'b1;
        repeat (20) cycle();
        btn[0] = 1'b0;
        while (k < 25) cycle();
        chk("t5_time", 32'(obs), 32'(pack(0, 0, T5_SECS)));
        chk("t5_drain", q.size(), 0);
        tick_en = 1'b1;

        while (k % 10 > 5) cycle();
        btn[2] = 1'b1;
        cycle();
        btn[2] = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_time", 32'(obs), 32'(pack(0, 0, 0)));
        chk("t6_upd", 32'(update), 0);
        reset = 1'b0;
        k = 0;
        mh = 0; mm = 0; ms = 0;
        base = n_upd;
        repeat (10) cycle();
        chk("t6_quiet", n_upd - base, 0);
        chk("t6_tick", 32'(obs), 32'(pack(0, 0, 1)));
        chk("t6_tick_upd", 32'(update), 1);
        cycle();
        chk("t6_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
